decoder_nx2n_pipelined: RTL and testbench
=========================================

// Module: decoder_nx2n_pipelined
// PURPOSE
//  Parametrised N-to-2^N decoder with enable, registered output and valid/ready
//  handshake on both sides. Adds thermometer mode and active-low output option.
//  Two-entry skid buffer gives full throughput with a registered in_ready.
//  Sits between a select-code producer and per-line consumers (chip selects, mux enables).
// PARAMETERS
//  N           2   select width; output width is 2**N (legal 1..6)
//  ACTIVE_LOW  0   1 = invert every output bit (inactive level becomes 1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      input transaction present
//  in_ready   out  1      block can accept; registered
//  in_a       in   N      select code
//  in_en      in   1      0 = decode to all-inactive
//  in_mode    in   1      0 = one-hot, 1 = thermometer
//  out_valid  out  1      out_y holds a decoded word
//  out_ready  in   1      consumer accepts out_y
//  out_y      out  2**N   decoded word
// BEHAVIOUR
//  - Clocking: one clock (clk); reset rst is synchronous and active-high.
//  - Reset: out_valid=0, out_y=INACTIVE (all 0; all 1 if ACTIVE_LOW), skid empty,
//    in_ready=1 from first edge after rst deasserts (0 while rst is sampled high).
//  - Accept = in_valid & in_ready; consume = out_valid & out_ready.
//  - Decode (computed at accept; rst has priority over everything):
//    en=0 -> all inactive; mode0 -> only bit a active; mode1 -> bits 0..a active.
//    Example N=2: a=2 one-hot 0100, thermometer 0111; ACTIVE_LOW inverts: 1011/1000.
//  - Latency: accept at edge k -> out_valid=1, out_y=result after edge k (1 cycle).
//  - Throughput: 1 word/cycle while out_ready=1.
//  - Output reg empty or consumed this cycle: accepted word loads output reg directly.
//  - Output reg full and not consumed: accepted word goes to skid reg; in_ready
//    drops to 0 after that edge.
//  - Skid full and consume: skid moves to output reg, skid clears, in_ready=1 next cycle.
//  - Order preserved; no word dropped or duplicated.
//  - Stall: while out_valid & ~out_ready, out_y and out_valid stay stable.
//  - out_valid=0: out_y holds INACTIVE (not last value).
//  - in_a, in_en, in_mode ignored when not accepted.
//  - rst mid-operation: both entries flushed, pending words lost, state as at reset.
//  - No X on outputs after first reset edge.
// STRUCTURE
//  - decoder_pkg: MODE_ONEHOT=1'b0, MODE_THERM=1'b1, function for INACTIVE level.
//  - Sub-module decoder_nx2n_comb (params N, ACTIVE_LOW; ports a, en, mode -> y):
//    pure combinational decode; the top module holds output reg, skid reg and control.
//  - Control: two valid flags (out_valid, skid_valid); in_ready = ~skid_valid.
// TESTING (N=2 unless noted; check out_y on each out_valid)
//  1 rst=1 3 cycles, then 0 -> out_valid=0, out_y=0000, in_ready=1 next cycle.
//  2 out_ready=1; stream (a,en,mode)=(3,0,0),(0,1,0),(1,1,0),(2,1,0),(3,1,0)
//    -> 0000,0001,0010,0100,1000 on consecutive cycles, 1-cycle latency.
//  3 mode=1, a=0..3, en=1 -> 0001,0011,0111,1111; ACTIVE_LOW=1 -> 1110,1100,1000,0000.
//  4 out_ready=0, push a=1 then a=2 -> in_ready=0 after 2nd accept, out_y=0010 held;
//    out_ready=1 -> 0010 then 0100, in_ready=1 again; no third word lost.
//  5 Two words pending, rst pulse 1 cycle -> out_valid=0, skid empty, in_ready=1 after.
//  6 N=4 random stream with random out_ready, 1000 words -> scoreboard order and values match.

Source files
------------

// File: rtl/decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : decoder_pkg                                                  |
// | Description : Shared constants and helpers for the N-to-2^N decoder.       |
// |               MODE_* encode the in_mode port; inactive_word() returns the  |
// |               idle output level for a given polarity (slice to width).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package decoder_pkg;

  localparam logic MODE_ONEHOT = 1'b0;
  localparam logic MODE_THERM  = 1'b1;

  // Widest supported output word (N = 6 -> 64 lines).
  localparam int unsigned MAX_W = 64;

  // Idle level of the output bus: all zeros, or all ones when active-low.
  function automatic logic [MAX_W-1:0] inactive_word(input logic active_low);
    return active_low ? {MAX_W{1'b1}} : {MAX_W{1'b0}};
  endfunction

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decoder_nx2n_comb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decoder_nx2n_comb                                            |
// | Description : Purely combinational N-to-2^N decode.                        |
// |               a    : select code (N bits)                                  |
// |               en   : 0 forces every line inactive                          |
// |               mode : MODE_ONEHOT -> only line a active                     |
// |                      MODE_THERM  -> lines 0..a active                      |
// |               y    : decoded word (2^N bits), inverted when ACTIVE_LOW     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module decoder_nx2n_comb
  import decoder_pkg::*;
#(
  parameter int N          = 2,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [N-1:0]    a,
  input  logic            en,
  input  logic            mode,
  output logic [2**N-1:0] y
);

  localparam int W = 2**N;

  logic [W-1:0] raw;

  for (genvar i = 0; i < W; i++) begin : g_bit
    localparam logic [N-1:0] IDX = N'(i);
    // Line i is active when it equals the code (one-hot) or lies at/below it
    // (thermometer).
    assign raw[i] = en & ((mode == MODE_THERM) ? (IDX <= a) : (IDX == a));
  end

  assign y = ACTIVE_LOW ? ~raw : raw;

endmodule : decoder_nx2n_comb
`default_nettype wire

// File: rtl/decoder_nx2n_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decoder_nx2n_pipelined                                       |
// | Description : Registered N-to-2^N decoder with valid/ready on both sides   |
// |               and a two-entry (output + skid) buffer, so in_ready can be   |
// |               a flop while still sustaining one word per cycle.            |
// |   clk       in   1      rising-edge clock                                 |
// |   rst       in   1      synchronous reset, active-high                    |
// |   in_valid  in   1      input word present                                |
// |   in_ready  out  1      block can accept (registered)                     |
// |   in_a      in   N      select code                                       |
// |   in_en     in   1      0 = decode to all-inactive                        |
// |   in_mode   in   1      0 = one-hot, 1 = thermometer                      |
// |   out_valid out  1      out_y holds a decoded word                        |
// |   out_ready in   1      consumer takes out_y                              |
// |   out_y     out  2**N   decoded word (inactive level when !out_valid)     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module decoder_nx2n_pipelined
  import decoder_pkg::*;
#(
  parameter int N          = 2,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic            in_en,
  input  logic            in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2**N-1:0] out_y
);

  localparam int             W        = 2**N;
  localparam logic [W-1:0]   INACTIVE = W'(inactive_word(ACTIVE_LOW));

  logic [W-1:0] dec_word;

  logic         out_valid_q,  out_valid_d;
  logic [W-1:0] out_y_q,      out_y_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_y_q,     skid_y_d;
  logic         in_ready_q,   in_ready_d;

  logic         accept;
  logic         consume;

  decoder_nx2n_comb #(
    .N          (N),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_decode (
    .a    (in_a),
    .en   (in_en),
    .mode (in_mode),
    .y    (dec_word)
  );

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  // in_ready mirrors ~skid_valid, so accept and a full skid never coincide;
  // a skid entry can therefore only leave, never be overwritten.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_y_d      = out_y_q;
    skid_valid_d = skid_valid_q;
    skid_y_d     = skid_y_q;

    if (skid_valid_q && consume) begin
      // Oldest pending word moves forward; skid frees up.
      out_valid_d  = 1'b1;
      out_y_d      = skid_y_q;
      skid_valid_d = 1'b0;
      skid_y_d     = INACTIVE;
    end else if (!out_valid_q || consume) begin
      // Output slot is free this cycle: load directly or go idle.
      out_valid_d = accept;
      out_y_d     = accept ? dec_word : INACTIVE;
    end else if (accept) begin
      // Output stalled: park the new word in the skid slot.
      skid_valid_d = 1'b1;
      skid_y_d     = dec_word;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_y_q      <= INACTIVE;
      skid_valid_q <= 1'b0;
      skid_y_q     <= INACTIVE;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_y_q      <= out_y_d;
      skid_valid_q <= skid_valid_d;
      skid_y_q     <= skid_y_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;

endmodule : decoder_nx2n_pipelined
`default_nettype wire

// File: tb/tb_decoder_nx2n_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_decoder_nx2n_pipelined                                    |
// | Description : Directed bench for decoder_nx2n_pipelined. Three instances:  |
// |               N=2 active-high, N=2 active-low (same inputs), and N=4 for   |
// |               a long randomised stream against a queue scoreboard.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_decoder_nx2n_pipelined;

  logic        clk = 1'b0;
  logic        rst;

  // Shared stimulus for the two N=2 instances.
  logic        in_valid, in_en, in_mode, out_ready;
  logic [1:0]  in_a;
  logic        in_ready, out_valid;
  logic [3:0]  out_y;
  logic        in_ready_al, out_valid_al;
  logic [3:0]  out_y_al;

  // N=4 instance.
  logic        in_valid4, in_en4, in_mode4, out_ready4;
  logic [3:0]  in_a4;
  logic        in_ready4, out_valid4;
  logic [15:0] out_y4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_nx2n_pipelined #(.N(2), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_en(in_en), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  decoder_nx2n_pipelined #(.N(2), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_al),
    .in_a(in_a), .in_en(in_en), .in_mode(in_mode),
    .out_valid(out_valid_al), .out_ready(out_ready), .out_y(out_y_al)
  );

  decoder_nx2n_pipelined #(.N(4), .ACTIVE_LOW(1'b0)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_en(in_en4), .in_mode(in_mode4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_y(out_y4)
  );

  function automatic logic [15:0] model16(input logic [3:0] a, input logic en,
                                          input logic mode);
    logic [16:0] t;
    if (!en) return 16'h0000;
    if (mode) begin
      t = (17'd1 << (int'(a) + 1)) - 17'd1;
      return t[15:0];
    end
    return 16'd1 << a;
  endfunction

  // Advance one edge and settle just after it.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 0; in_a = 0; in_en = 0; in_mode = 0; out_ready = 0;
    in_valid4 = 0; in_a4 = 0; in_en4 = 0; in_mode4 = 0; out_ready4 = 0;
    repeat (3) step();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || out_y !== 4'b0000) begin
      errors++; $display("FAIL reset_out: got valid=%b y=%b expected valid=0 y=0000", out_valid, out_y);
    end
    checks++;
    if (out_valid_al !== 1'b0 || out_y_al !== 4'b1111) begin
      errors++; $display("FAIL reset_out_al: got valid=%b y=%b expected valid=0 y=1111", out_valid_al, out_y_al);
    end
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || in_ready4 !== 1'b1 || in_ready_al !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_high: got %b%b%b expected 111", in_ready, in_ready_al, in_ready4);
    end
    checks++;
    if (out_valid !== 1'b0 || out_y !== 4'b0000 || out_y4 !== 16'h0000) begin
      errors++; $display("FAIL reset_idle: got valid=%b y=%b y4=%h expected 0/0000/0000", out_valid, out_y, out_y4);
    end
  endtask

  task automatic test_onehot_stream;
    logic [1:0] a_v  [5] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic       en_v [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_v[5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    out_ready = 1'b1;
    in_mode   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = a_v[i]; in_en = en_v[i];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_y !== exp_v[i] || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL onehot_%0d: got valid=%b y=%b rdy=%b expected valid=1 y=%b rdy=1",
                 i, out_valid, out_y, in_ready, exp_v[i]);
      end
    end
    in_valid = 1'b0;
    in_a = 2'd2; in_en = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_y !== 4'b0000) begin
      errors++; $display("FAIL onehot_idle: got valid=%b y=%b expected valid=0 y=0000", out_valid, out_y);
    end
  endtask

  task automatic test_thermometer;
    logic [3:0] exp_h[4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    logic [3:0] exp_l[4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    out_ready = 1'b1;
    in_mode   = 1'b1;
    in_en     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 2'(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_y !== exp_h[i]) begin
        errors++; $display("FAIL therm_%0d: got valid=%b y=%b expected valid=1 y=%b", i, out_valid, out_y, exp_h[i]);
      end
      checks++;
      if (out_valid_al !== 1'b1 || out_y_al !== exp_l[i]) begin
        errors++; $display("FAIL therm_al_%0d: got valid=%b y=%b expected valid=1 y=%b", i, out_valid_al, out_y_al, exp_l[i]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid_al !== 1'b0 || out_y_al !== 4'b1111) begin
      errors++; $display("FAIL therm_al_idle: got valid=%b y=%b expected valid=0 y=1111", out_valid_al, out_y_al);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    in_mode = 1'b0; in_en = 1'b1;
    in_valid = 1'b1; in_a = 2'd1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_y !== 4'b0010 || in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_first: got valid=%b y=%b rdy=%b expected 1/0010/1", out_valid, out_y, in_ready);
    end
    in_a = 2'd2;
    step();
    checks++;
    if (in_ready !== 1'b0 || out_y !== 4'b0010 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_skid: got valid=%b y=%b rdy=%b expected 1/0010/0", out_valid, out_y, in_ready);
    end
    // Third word offered while full: must wait, not overwrite.
    in_a = 2'd3;
    step();
    checks++;
    if (in_ready !== 1'b0 || out_y !== 4'b0010 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_hold: got valid=%b y=%b rdy=%b expected 1/0010/0", out_valid, out_y, in_ready);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_y !== 4'b0100 || in_ready !== 1'b1) begin
      errors++; $display("FAIL drain_skid: got valid=%b y=%b rdy=%b expected 1/0100/1", out_valid, out_y, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_y !== 4'b1000) begin
      errors++; $display("FAIL third_word: got valid=%b y=%b expected valid=1 y=1000", out_valid, out_y);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_y !== 4'b0000) begin
      errors++; $display("FAIL drain_idle: got valid=%b y=%b expected valid=0 y=0000", out_valid, out_y);
    end
  endtask

  task automatic test_reset_flush;
    out_ready = 1'b0;
    in_mode = 1'b0; in_en = 1'b1;
    in_valid = 1'b1; in_a = 2'd0;
    step();
    in_a = 2'd3;
    step();
    checks++;
    if (in_ready !== 1'b0 || out_y !== 4'b0001) begin
      errors++; $display("FAIL flush_setup: got y=%b rdy=%b expected y=0001 rdy=0", out_y, in_ready);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_y !== 4'b0000 || out_y_al !== 4'b1111) begin
      errors++; $display("FAIL flush_out: got valid=%b y=%b yal=%b expected 0/0000/1111", out_valid, out_y, out_y_al);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got rdy=%b valid=%b expected rdy=1 valid=0", in_ready, out_valid);
    end
    // Skid contents must be gone: nothing appears on the output afterwards.
    step();
    checks++;
    if (out_valid !== 1'b0 || out_y !== 4'b0000) begin
      errors++; $display("FAIL flush_skid: got valid=%b y=%b expected valid=0 y=0000", out_valid, out_y);
    end
  endtask

  task automatic test_random_stream;
    logic [15:0] q[$];
    logic [15:0] prev_y;
    int          sent   = 0;
    int          got    = 0;
    int          cycles = 0;
    bit          acc, con, stall;
    while ((sent < 1000 || q.size() != 0) && cycles < 20000) begin
      if (sent < 1000) begin
        in_valid4 = ($urandom_range(0, 3) != 0);
        in_a4     = 4'($urandom_range(0, 15));
        in_en4    = ($urandom_range(0, 7) != 0);
        in_mode4  = 1'($urandom_range(0, 1));
      end else begin
        in_valid4 = 1'b0;
      end
      out_ready4 = ($urandom_range(0, 3) != 0);
      acc   = in_valid4 && in_ready4;
      con   = out_valid4 && out_ready4;
      stall = out_valid4 && !out_ready4;
      prev_y = out_y4;
      if (con) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra: got y=%h expected no word", out_y4);
        end else begin
          if (out_y4 !== q[0]) begin
            errors++; $display("FAIL rand_word_%0d: got y=%h expected %h", got, out_y4, q[0]);
          end
          void'(q.pop_front());
        end
        got++;
      end else if (!out_valid4) begin
        checks++;
        if (out_y4 !== 16'h0000) begin
          errors++; $display("FAIL rand_idle: got y=%h expected 0000", out_y4);
        end
      end
      if (acc) begin
        q.push_back(model16(in_a4, in_en4, in_mode4));
        sent++;
      end
      step();
      cycles++;
      if (stall) begin
        checks++;
        if (out_valid4 !== 1'b1 || out_y4 !== prev_y) begin
          errors++; $display("FAIL rand_stall: got valid=%b y=%h expected valid=1 y=%h", out_valid4, out_y4, prev_y);
        end
      end
    end
    checks++;
    if (got != 1000 || cycles >= 20000) begin
      errors++; $display("FAIL rand_count: got %0d words in %0d cycles expected 1000", got, cycles);
    end
  endtask

  initial begin
    test_reset();
    test_onehot_stream();
    test_thermometer();
    test_back_to_back();
    test_reset_flush();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_decoder_nx2n_pipelined
`default_nettype wire
